alu_cmd_issuer: RTL and testbench
=================================

# alu_cmd_issuer

Command-side driver for the combinational 32-bit ALU: accepts operation requests over a valid/ready stream, buffers them in a small FIFO, presents each to the ALU's `a`/`b`/`ALUControl` inputs, and returns registered results with a sequence tag over a second valid/ready stream. Sits between an instruction/test sequencer and the ALU instance, turning the ALU's purely combinational interface into a flow-controlled, back-pressurable pipeline stage.

## Interface
- `WIDTH`, 32, operand/result width
- `DEPTH`, 4, command FIFO entries (power of two, ≥2)
- `TAG_W`, 8, response sequence-tag width
- `clk` input 1: single clock, all logic on rising edge
- `rst` input 1: synchronous reset, active-high
- `cmd_valid` input 1: command present
- `cmd_ready` output 1: command FIFO can accept
- `cmd_a` input WIDTH: operand a
- `cmd_b` input WIDTH: operand b
- `cmd_op` input 3: ALU opcode
- `alu_a` output WIDTH: to ALU `a`
- `alu_b` output WIDTH: to ALU `b`
- `alu_control` output 3: to ALU `ALUControl`
- `alu_result` input WIDTH: from ALU `result`
- `rsp_valid` output 1: response held
- `rsp_ready` input 1: consumer takes response
- `rsp_result` output WIDTH: captured result
- `rsp_tag` output TAG_W: sequence number of this response
- `rsp_err` output 1: reserved opcode flagged (see Configuration)

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 XOR, 101 SLT (signed, result 1/0); 100, 110, 111 reserved.
- Push: `cmd_valid && cmd_ready` on an edge writes {a,b,op} to FIFO tail.
- `cmd_ready = !rst && (count != DEPTH)`; no same-cycle pass-through when full (full FIFO deasserts ready even if a pop occurs that cycle).
- FIFO head drives `alu_a/alu_b/alu_control` combinationally; FIFO empty → drive 0/0/000.
- Load condition: FIFO non-empty && (!rsp_valid || rsp_ready). On load: pop head, `rsp_result <= alu_result`, `rsp_tag <= tag_cnt`, `rsp_valid <= 1`, `tag_cnt <= tag_cnt+1`.
- `rsp_valid` drops only when `rsp_ready` and no load that cycle; outputs stable while `rsp_valid && !rsp_ready`.
- Simultaneous push and pop: count unchanged, both take effect.
- `tag_cnt` wraps 2^TAG_W−1 → 0 silently.
- Reset (any time, including mid-stream): FIFO flushed, count 0, `tag_cnt` 0, `rsp_valid` 0, `rsp_result` 0, `rsp_tag` 0, `rsp_err` 0; in-flight commands discarded.

## Timing
- Command accepted on edge k → `rsp_valid` high after edge k+1 (2-cycle latency, FIFO empty, output free).
- Throughput 1 result/cycle with `rsp_ready` held high.
- `cmd_ready` 0 during reset cycle, 1 in first cycle after `rst` deasserts.
- Backpressure: with `rsp_ready` low, DEPTH further commands accepted, then `cmd_ready` falls.

## Configuration
- `ALU_ISSUER_OPCHECK_EN` defined: reserved opcodes still popped in order, but `rsp_result` = 0 and `rsp_err` = 1 for that response; `alu_control` driven 000 for that entry.
- Undefined: reserved opcodes forwarded unchanged to ALU, whatever `alu_result` returns is captured, `rsp_err` tied 0.

## Structure
- Shared package `alu_pkg`: opcode constants (OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_SLT), default WIDTH, command struct/packed layout {op,a,b}.
- One sub-module: `alu_cmd_fifo` (synchronous FIFO, WIDTH·2+3 bits, DEPTH entries, count/full/empty, same-cycle push+pop).

## Test plan
- Single ADD a=12,b=8, rsp_ready=1 → after 2 cycles rsp_valid=1, rsp_result=20, rsp_tag=0.
- Back-to-back SUB 20−5, AND F0F0F0F0&0F0F0F0F, XOR AAAA5555^12345678, SLT 5<10 → results 15, 0, B89E032D, 1 on consecutive cycles, tags 0..3.
- rsp_ready=0, push 6 commands → 5 accepted (4 FIFO + 1 output reg), cmd_ready low; release → all 5 drain in order, outputs stable while stalled.
- 257 commands with TAG_W=8 → tag 255 followed by tag 0.
- Assert rst with 3 queued and rsp_valid=1 → next cycle rsp_valid=0, rsp_result=0, cmd_ready=1, next command returns tag 0.
- op=110 with ALU_ISSUER_OPCHECK_EN → rsp_err=1, rsp_result=0; without macro → rsp_err=0, result equals ALU output.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, default operand width and command layout shared by the ALU issuer.
package alu_pkg;
    localparam int ALU_WIDTH = 32;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    typedef struct packed {
        logic [2:0]           op;
        logic [ALU_WIDTH-1:0] a;
        logic [ALU_WIDTH-1:0] b;
    } alu_cmd_t;

    function automatic logic op_reserved(input logic [2:0] op);
        return !(op inside {OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_SLT});
    endfunction
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO for packed {op,a,b} commands; caller never pushes when full or pops when empty.
module alu_cmd_fifo #(
    parameter int W     = 67,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;

    assign o_data  = r_mem[r_rd];
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end
endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU requests, drives the combinational ALU from the FIFO head and returns tagged results.
// Define ALU_ISSUER_OPCHECK_EN to trap reserved opcodes (result 0, rsp_err 1) instead of forwarding them.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);
    localparam int DW = 2*WIDTH + 3;

    logic [DW-1:0]    w_head;
    logic [2:0]       w_head_op;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_rsvd;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_result;
    logic [TAG_W-1:0] r_rsp_tag;
    logic             r_rsp_err;
    logic [TAG_W-1:0] r_tag_cnt;

    alu_cmd_fifo #(.W(DW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({cmd_op, cmd_a, cmd_b}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Ready ignores a same-cycle pop: a full FIFO never accepts.
    assign cmd_ready = !rst && !w_full;
    assign w_push    = cmd_valid && cmd_ready;
    assign w_pop     = !w_empty && (!r_rsp_valid || rsp_ready);
    assign w_head_op = w_head[DW-1 -: 3];

`ifdef ALU_ISSUER_OPCHECK_EN
    assign w_rsvd = !w_empty && op_reserved(w_head_op);
`else
    assign w_rsvd = 1'b0;
`endif

    assign alu_a       = w_empty ? '0 : w_head[2*WIDTH-1 -: WIDTH];
    assign alu_b       = w_empty ? '0 : w_head[WIDTH-1:0];
    assign alu_control = (w_empty || w_rsvd) ? OP_ADD : w_head_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_tag    <= '0;
            r_rsp_err    <= 1'b0;
            r_tag_cnt    <= '0;
        end else if (w_pop) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= w_rsvd ? '0 : alu_result;
            r_rsp_tag    <= r_tag_cnt;
            r_rsp_err    <= w_rsvd;
            r_tag_cnt    <= r_tag_cnt + 1'b1;
        end else if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_tag    = r_rsp_tag;
    assign rsp_err    = r_rsp_err;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed and random stimulus against an in-order response model with a behavioural ALU.
module tb_alu_cmd_issuer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic [2:0]  cmd_op = '0;
    logic        cmd_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic [31:0] rsp_result;
    logic [7:0]  rsp_tag;
    logic        rsp_err;

    typedef struct {
        logic [31:0] res;
        logic [7:0]  tag;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  tag_log[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_acc = 0;
    int          acc_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_res = '0;
    logic [7:0]  prev_tag = '0;
    logic [2:0]  legal_ops [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};

    alu_cmd_issuer dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_op      (cmd_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_tag     (rsp_tag),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    // Environment ALU; reserved opcodes return a recognisable pattern.
    function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a ^ b ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_control);

    function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic [2:0] op, int idx);
        exp_t e;
        e.tag = 8'(idx % 256);
`ifdef ALU_ISSUER_OPCHECK_EN
        e.err = (op == 3'd4) || (op == 3'd6) || (op == 3'd7);
        e.res = e.err ? 32'd0 : alu_f(a, b, op);
`else
        e.err = 1'b0;
        e.res = alu_f(a, b, op);
`endif
        return e;
    endfunction

    task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One clock: check against the model at the falling edge, then update the model at the rising edge.
    task automatic tick();
        logic        acc;
        logic        take;
        logic [31:0] ca;
        logic [31:0] cb;
        logic [2:0]  cop;
        logic [7:0]  t;
        @(negedge clk);
        acc  = 1'b0;
        take = 1'b0;
        ca   = cmd_a;
        cb   = cmd_b;
        cop  = cmd_op;
        t    = rsp_tag;
        if (rst) begin
            chk("ready_in_rst", cmd_ready, 0);
        end else begin
            chk("cmd_ready", cmd_ready, (exp_q.size() - int'(rsp_valid)) != DEPTH);
            if (prev_stall) begin
                chk("stall_valid", rsp_valid, 1);
                chk("stall_result", rsp_result, prev_res);
                chk("stall_tag", rsp_tag, prev_tag);
            end
            if (rsp_valid) begin
                chk("rsp_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("rsp_result", rsp_result, exp_q[0].res);
                    chk("rsp_tag", rsp_tag, exp_q[0].tag);
                    chk("rsp_err", rsp_err, exp_q[0].err);
                end
            end
            acc  = cmd_valid && cmd_ready;
            take = rsp_valid && rsp_ready;
        end
        prev_stall = !rst && rsp_valid && !rsp_ready;
        prev_res   = rsp_result;
        prev_tag   = rsp_tag;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            n_acc = 0;
        end else begin
            if (take && exp_q.size() != 0) begin
                exp_q.delete(0);
                tag_log.push_back(t);
            end
            if (acc) begin
                exp_q.push_back(model(ca, cb, cop, n_acc));
                n_acc++;
                acc_cnt++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic drive(logic [31:0] a, logic [31:0] b, logic [2:0] op);
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
    endtask

    task automatic wait_valid(string name);
        for (int i = 0; i < 10 && !rsp_valid; i++) tick();
        chk(name, rsp_valid, 1);
    endtask

    task automatic drain(string name);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 40 && (exp_q.size() != 0 || rsp_valid); i++) tick();
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        logic [31:0] a2 [4] = '{32'd20, 32'hF0F0_F0F0, 32'hAAAA_5555, 32'd5};
        logic [31:0] b2 [4] = '{32'd5, 32'h0F0F_0F0F, 32'h1234_5678, 32'd10};
        logic [2:0]  o2 [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
        logic [31:0] r2 [4] = '{32'd15, 32'd0, 32'hB89E_032D, 32'd1};

        // Reset state
        tick();
        tick();
        chk("rst_valid", rsp_valid, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_tag", rsp_tag, 0);
        chk("rst_err", rsp_err, 0);
        chk("empty_alu_a", alu_a, 0);
        chk("empty_alu_ctl", alu_control, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", cmd_ready, 1);

        // Single ADD, two-cycle latency
        rsp_ready = 1'b1;
        drive(32'd12, 32'd8, 3'd0);
        tick();
        cmd_valid = 1'b0;
        chk("t1_lat_valid", rsp_valid, 0);
        chk("t1_alu_a", alu_a, 12);
        chk("t1_alu_b", alu_b, 8);
        tick();
        chk("t1_valid", rsp_valid, 1);
        chk("t1_result", rsp_result, 20);
        chk("t1_tag", rsp_tag, 0);
        drain("t1_drained");

        // Back-to-back, one result per cycle
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(a2[i], b2[i], o2[i]);
            tick();
            if (i > 0) begin
                chk("t2_valid", rsp_valid, 1);
                chk("t2_result", rsp_result, r2[i-1]);
                chk("t2_tag", rsp_tag, i - 1);
            end
        end
        cmd_valid = 1'b0;
        tick();
        chk("t2_valid_last", rsp_valid, 1);
        chk("t2_result_last", rsp_result, r2[3]);
        chk("t2_tag_last", rsp_tag, 3);
        drain("t2_drained");

        // Backpressure: FIFO plus output register absorb DEPTH+1 commands
        rsp_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            drive($urandom, $urandom, legal_ops[$urandom_range(0, 4)]);
            tick();
        end
        cmd_valid = 1'b0;
        chk("t3_accepted", acc_cnt, DEPTH + 1);
        chk("t3_ready_low", cmd_ready, 0);
        chk("t3_valid", rsp_valid, 1);
        tick();
        tick();
        drain("t3_drained");

        // Tag wrap after 256 responses
        do_reset();
        tag_log.delete();
        rsp_ready = 1'b1;
        acc_cnt = 0;
        for (int i = 0; i < 600 && acc_cnt < 257; i++) begin
            drive($urandom, $urandom, legal_ops[$urandom_range(0, 4)]);
            tick();
        end
        drain("t4_drained");
        chk("t4_count", tag_log.size(), 257);
        if (tag_log.size() >= 257) begin
            chk("t4_tag255", tag_log[255], 255);
            chk("t4_tag_wrap", tag_log[256], 0);
        end

        // Reset mid-stream
        rsp_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 10 && acc_cnt < 4; i++) begin
            drive($urandom, $urandom, legal_ops[$urandom_range(0, 4)]);
            tick();
        end
        cmd_valid = 1'b0;
        chk("t5_valid_before", rsp_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t5_valid", rsp_valid, 0);
        chk("t5_result", rsp_result, 0);
        chk("t5_tag", rsp_tag, 0);
        chk("t5_ready", cmd_ready, 1);
        rsp_ready = 1'b1;
        drive(32'd100, 32'd1, 3'd1);
        tick();
        cmd_valid = 1'b0;
        wait_valid("t5_new_valid");
        chk("t5_new_tag", rsp_tag, 0);
        chk("t5_new_result", rsp_result, 99);
        drain("t5_drained");

        // Reserved opcode
        drive(32'd7, 32'd3, 3'b110);
        tick();
        cmd_valid = 1'b0;
`ifdef ALU_ISSUER_OPCHECK_EN
        chk("t6_alu_ctl", alu_control, 0);
`else
        chk("t6_alu_ctl", alu_control, 6);
`endif
        wait_valid("t6_valid");
`ifdef ALU_ISSUER_OPCHECK_EN
        chk("t6_err", rsp_err, 1);
        chk("t6_result", rsp_result, 0);
`else
        chk("t6_err", rsp_err, 0);
        chk("t6_result", rsp_result, 32'h5A5A_5A5E);
`endif
        drain("t6_drained");

        // Random traffic with random backpressure and all opcodes
        for (int i = 0; i < 400; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_a = $urandom;
            cmd_b = ($urandom_range(0, 3) == 0) ? cmd_a : $urandom;
            cmd_op = 3'($urandom_range(0, 7));
            rsp_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        drain("t7_drained");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
